// File: rtl/memory_arbiter.sv
// Two-client round-robin arbiter for a shared memory port, with write-snoop invalidates.
// A four-state FSM sequences each transaction; every output comes straight from a register.
`timescale 1ns/1ps
module memory_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [24:0] req0,
    input  logic [24:0] req1,
    input  logic        req0_ready,
    input  logic        req1_ready,
    output logic [15:0] resp0,
    output logic [15:0] resp1,
    output logic        resp0_ready,
    output logic        resp1_ready,
    output logic [15:0] inval0_address,
    output logic [15:0] inval1_address,
    output logic        inval0_valid,
    output logic        inval1_valid,
    output logic [24:0] mem_request,
    output logic        mem_request_ready,
    input  logic [15:0] mem_response,
    input  logic        mem_response_ready,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, RELEASE} state_t;

    state_t      state, state_nxt;
    logic        pointer, pointer_nxt;
    logic        owner, owner_nxt;
    logic [1:0]  grant_nxt;
    logic [24:0] mem_request_nxt;
    logic        mem_request_ready_nxt;
    logic [15:0] resp0_nxt, resp1_nxt;
    logic        resp0_ready_nxt, resp1_ready_nxt;
    logic [15:0] inval0_address_nxt, inval1_address_nxt;
    logic        inval0_valid_nxt, inval1_valid_nxt;

    logic        pick;
    logic [24:0] granted_req;
    logic        owner_ready;

    // With both clients asking, the pointer decides; otherwise the lone requester wins.
    assign pick        = (req0_ready && req1_ready) ? pointer : req1_ready;
    assign granted_req = pick ? req1 : req0;
    assign owner_ready = owner ? req1_ready : req0_ready;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_nxt             = state;
        pointer_nxt           = pointer;
        owner_nxt             = owner;
        grant_nxt             = grant;
        mem_request_nxt       = mem_request;
        mem_request_ready_nxt = mem_request_ready;
        resp0_nxt             = resp0;
        resp1_nxt             = resp1;
        resp0_ready_nxt       = resp0_ready;
        resp1_ready_nxt       = resp1_ready;
        inval0_address_nxt    = inval0_address;
        inval1_address_nxt    = inval1_address;
        inval0_valid_nxt      = 1'b0;
        inval1_valid_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    owner_nxt             = pick;
                    pointer_nxt           = ~pick;
                    grant_nxt             = pick ? 2'b10 : 2'b01;
                    mem_request_nxt       = granted_req;
                    mem_request_ready_nxt = 1'b1;
                    state_nxt             = ISSUE;
                    if (granted_req[24]) begin
                        // A write makes the other cache's copy stale.
                        if (pick) begin
                            inval0_address_nxt = granted_req[15:0];
                            inval0_valid_nxt   = 1'b1;
                        end else begin
                            inval1_address_nxt = granted_req[15:0];
                            inval1_valid_nxt   = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (mem_response_ready) begin
                    if (owner) begin
                        resp1_nxt       = mem_response;
                        resp1_ready_nxt = 1'b1;
                    end else begin
                        resp0_nxt       = mem_response;
                        resp0_ready_nxt = 1'b1;
                    end
                    mem_request_ready_nxt = 1'b0;
                    state_nxt             = RESP;
                end
            end
            RESP: begin
                if (!owner_ready) begin
                    resp0_ready_nxt = 1'b0;
                    resp1_ready_nxt = 1'b0;
                    state_nxt       = RELEASE;
                end
            end
            RELEASE: begin
                if (!mem_response_ready) begin
                    grant_nxt = 2'b00;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            pointer           <= 1'b0;
            owner             <= 1'b0;
            grant             <= 2'b00;
            mem_request       <= '0;
            mem_request_ready <= 1'b0;
            resp0             <= '0;
            resp1             <= '0;
            resp0_ready       <= 1'b0;
            resp1_ready       <= 1'b0;
            inval0_address    <= '0;
            inval1_address    <= '0;
            inval0_valid      <= 1'b0;
            inval1_valid      <= 1'b0;
        end else begin
            state             <= state_nxt;
            pointer           <= pointer_nxt;
            owner             <= owner_nxt;
            grant             <= grant_nxt;
            mem_request       <= mem_request_nxt;
            mem_request_ready <= mem_request_ready_nxt;
            resp0             <= resp0_nxt;
            resp1             <= resp1_nxt;
            resp0_ready       <= resp0_ready_nxt;
            resp1_ready       <= resp1_ready_nxt;
            inval0_address    <= inval0_address_nxt;
            inval1_address    <= inval1_address_nxt;
            inval0_valid      <= inval0_valid_nxt;
            inval1_valid      <= inval1_valid_nxt;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed transactions push expected grants/responses,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [24:0] req0, req1;
    logic        req0_ready, req1_ready;
    logic [15:0] resp0, resp1;
    logic        resp0_ready, resp1_ready;
    logic [15:0] inval0_address, inval1_address;
    logic        inval0_valid, inval1_valid;
    logic [24:0] mem_request;
    logic        mem_request_ready;
    logic [15:0] mem_response;
    logic        mem_response_ready;
    logic [1:0]  grant;

    memory_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp0(resp0), .resp1(resp1), .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .inval0_address(inval0_address), .inval1_address(inval1_address),
        .inval0_valid(inval0_valid), .inval1_valid(inval1_valid),
        .mem_request(mem_request), .mem_request_ready(mem_request_ready),
        .mem_response(mem_response), .mem_response_ready(mem_response_ready),
        .grant(grant)
    );

    always #5 clock = ~clock;

    // Memory model: answers after mem_delay edges of seeing the request, holds until it drops.
    int mem_delay;
    int wait_cnt = 0;
    always @(posedge clock) wait_cnt <= mem_request_ready ? wait_cnt + 1 : 0;
    assign mem_response_ready = mem_request_ready && (wait_cnt >= mem_delay);
    assign mem_response = (mem_request[15:0] == 16'h000C) ? 16'h3837 : {8'hA5, mem_request[7:0]};

    typedef struct { logic [1:0] grant; logic [24:0] mem_req; } issue_t;
    typedef struct { logic client; logic [15:0] data; } resp_t;
    issue_t issue_q[$];
    resp_t  resp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor
    logic   prev_mrr = 1'b0, prev_r0 = 1'b0, prev_r1 = 1'b0;
    logic   mon_i0, mon_i1;
    issue_t mon_issue;
    resp_t  mon_resp;

    always @(negedge clock) begin
        mon_i0 = 1'b0;
        mon_i1 = 1'b0;
        if (!reset) begin
            if (mem_request_ready && !prev_mrr) begin
                if (issue_q.size() == 0) check("issue_unexpected", 1, 0);
                else begin
                    mon_issue = issue_q.pop_front();
                    check("mem_request", mem_request, mon_issue.mem_req);
                    check("grant", grant, mon_issue.grant);
                    if (mon_issue.mem_req[24]) begin
                        if (mon_issue.grant[0]) begin
                            mon_i1 = 1'b1;
                            check("inval1_address", inval1_address, mon_issue.mem_req[15:0]);
                        end else begin
                            mon_i0 = 1'b1;
                            check("inval0_address", inval0_address, mon_issue.mem_req[15:0]);
                        end
                    end
                end
            end
            check("inval0_valid", inval0_valid, mon_i0);
            check("inval1_valid", inval1_valid, mon_i1);
            if ((resp0_ready && !prev_r0) || (resp1_ready && !prev_r1)) begin
                if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
                else begin
                    mon_resp = resp_q.pop_front();
                    check("resp_client", {resp1_ready, resp0_ready}, mon_resp.client ? 2'b10 : 2'b01);
                    check("resp_data", mon_resp.client ? resp1 : resp0, mon_resp.data);
                end
            end
        end
        prev_mrr = mem_request_ready;
        prev_r0  = resp0_ready;
        prev_r1  = resp1_ready;
    end

    task automatic drive_client(input int c, input logic [24:0] r, input logic rdy);
        if (c == 0) begin req0 = r; req0_ready = rdy; end
        else        begin req1 = r; req1_ready = rdy; end
    endtask

    // Raise a request, wait (bounded) for the response, hold `hold` extra cycles, then release.
    task automatic client_txn(input int c, input logic [24:0] r, input int hold,
                              input int exp_lat, input int exp_busy, output int lat);
        int  busy = 0;
        bit  got  = 0;
        lat = 0;
        drive_client(c, r, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            lat++;
            if (mem_request_ready && grant[c]) busy++;
            if ((c == 0) ? resp0_ready : resp1_ready) begin got = 1; break; end
        end
        check($sformatf("resp%0d_seen", c), got, 1);
        if (exp_lat >= 0)  check($sformatf("latency%0d", c), lat, exp_lat);
        if (exp_busy >= 0) check("mem_request_ready_cycles", busy, exp_busy);
        for (int i = 0; i < hold; i++) begin
            if (i == 0) drive_client(c, ~r, 1'b1);
            @(negedge clock);
            check("resp_ready_held", (c == 0) ? resp0_ready : resp1_ready, 1);
            check("grant_held", grant, (c == 0) ? 2'b01 : 2'b10);
            check("mem_request_latched", mem_request, r);
        end
        drive_client(c, '0, 1'b0);
    endtask

    task automatic wait_idle(output int n);
        bit done = 0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            n++;
            if (grant == 2'b00 && !mem_request_ready) begin done = 1; break; end
        end
        check("returned_idle", done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_mem_request"}, mem_request, 0);
        check({tag, "_mem_request_ready"}, mem_request_ready, 0);
        check({tag, "_resp"}, {resp1, resp0}, 0);
        check({tag, "_resp_ready"}, {resp1_ready, resp0_ready}, 0);
        check({tag, "_inval_address"}, {inval1_address, inval0_address}, 0);
        check({tag, "_inval_valid"}, {inval1_valid, inval0_valid}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat1, n;
        reset = 1'b1; req0 = '0; req1 = '0; req0_ready = 1'b0; req1_ready = 1'b0;
        mem_delay = 0;
        @(negedge clock);
        do_reset();
        check_all_zero("reset");

        // Cache 0 reads 0x000C; zero-wait memory.
        issue_q.push_back('{2'b01, 25'h000000C});
        resp_q.push_back('{1'b0, 16'h3837});
        client_txn(0, 25'h000000C, 0, 2, 1, lat);
        wait_idle(n);
        check("txn_cycles", lat + n, 4);

        // Cache 1 writes 0x37 to 0x000D: invalidates cache 0.
        issue_q.push_back('{2'b10, 25'h137000D});
        resp_q.push_back('{1'b1, 16'hA50D});
        client_txn(1, 25'h137000D, 0, 2, 1, lat);
        wait_idle(n);

        // A read leaves invalidate addresses untouched.
        issue_q.push_back('{2'b01, 25'h000000E});
        resp_q.push_back('{1'b0, 16'hA50E});
        client_txn(0, 25'h000000E, 0, 2, 1, lat);
        wait_idle(n);
        check("inval0_address_hold", inval0_address, 16'h000D);
        check("inval1_address_hold", inval1_address, 16'h0000);

        // Simultaneous pairs after reset: cache 0 wins both times.
        @(negedge clock);
        do_reset();
        issue_q.push_back('{2'b01, 25'h0000020});
        issue_q.push_back('{2'b10, 25'h0000030});
        resp_q.push_back('{1'b0, 16'hA520});
        resp_q.push_back('{1'b1, 16'hA530});
        fork
            client_txn(0, 25'h0000020, 0, 2, -1, lat);
            client_txn(1, 25'h0000030, 0, -1, -1, lat1);
        join
        wait_idle(n);
        issue_q.push_back('{2'b01, 25'h0000040});
        issue_q.push_back('{2'b10, 25'h1110050});
        resp_q.push_back('{1'b0, 16'hA540});
        resp_q.push_back('{1'b1, 16'hA550});
        fork
            client_txn(0, 25'h0000040, 0, 2, -1, lat);
            client_txn(1, 25'h1110050, 0, -1, -1, lat1);
        join
        wait_idle(n);
        check("inval0_address_pair", inval0_address, 16'h0050);

        // Slow memory: request held 5 cycles before the response.
        mem_delay = 4;
        issue_q.push_back('{2'b01, 25'h0000060});
        resp_q.push_back('{1'b0, 16'hA560});
        client_txn(0, 25'h0000060, 0, 6, 5, lat);
        wait_idle(n);
        mem_delay = 0;

        // Cache 0 holds its request 3 extra cycles; cache 1 waits until release.
        issue_q.push_back('{2'b01, 25'h0000070});
        issue_q.push_back('{2'b10, 25'h0000080});
        resp_q.push_back('{1'b0, 16'hA570});
        resp_q.push_back('{1'b1, 16'hA580});
        fork
            client_txn(0, 25'h0000070, 3, 2, 1, lat);
            begin
                repeat (2) @(negedge clock);
                client_txn(1, 25'h0000080, 0, -1, -1, lat1);
            end
        join
        wait_idle(n);

        // Reset while in ISSUE aborts the transaction with no response.
        mem_delay = 10;
        issue_q.push_back('{2'b01, 25'h0000090});
        drive_client(0, 25'h0000090, 1'b1);
        repeat (2) @(negedge clock);
        check("issue_pending", mem_request_ready, 1);
        reset = 1'b1;
        drive_client(0, '0, 1'b0);
        @(negedge clock);
        check_all_zero("abort");
        reset = 1'b0;
        mem_delay = 0;
        issue_q.push_back('{2'b10, 25'h00000A0});
        resp_q.push_back('{1'b1, 16'hA5A0});
        client_txn(1, 25'h00000A0, 0, 2, 1, lat);
        wait_idle(n);

        repeat (3) @(negedge clock);
        check("issue_queue_drained", issue_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
